// File: rtl/sap1_pkg.sv
// Shared widths, opcodes and bus-source encoding for the SAP-1 datapath.
package sap1_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned OP_W       = DEF_DATA_W - DEF_ADDR_W;

    localparam logic [OP_W-1:0] OP_LDA = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB = 4'h3;
    localparam logic [OP_W-1:0] OP_OUT = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        BUS_NONE,
        BUS_PC,
        BUS_IR,
        BUS_RAM,
        BUS_A,
        BUS_ALU
    } bus_src_t;

endpackage

// File: rtl/sap1_ram.sv
// Register-array program/data memory: asynchronous read, synchronous write, no reset.
module sap1_ram
    import sap1_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sap1_datapath.sv
// SAP-1 W-bus datapath: PC, MAR, RAM, IR, A, B, ALU and OUT, steered by the controller's control word.
module sap1_datapath
    import sap1_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     cp,
    input  logic                     ep,
    input  logic                     n_lm,
    input  logic                     n_ce,
    input  logic                     n_li,
    input  logic                     n_ei,
    input  logic                     n_la,
    input  logic                     ea,
    input  logic                     su,
    input  logic                     eu,
    input  logic                     n_lb,
    input  logic                     n_lo,
    input  logic                     prog_mode,
    input  logic                     prog_we,
    input  logic [ADDR_W-1:0]        prog_addr,
    input  logic [DATA_W-1:0]        prog_data,
    output logic [DATA_W-ADDR_W-1:0] instruction,
    output logic [DATA_W-1:0]        out_value,
    output logic [DATA_W-1:0]        bus,
    output logic                     carry,
    output logic                     zero,
    output logic                     bus_conflict
);

    localparam int unsigned PAD_W = DATA_W - ADDR_W;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] b_op;
    logic [DATA_W:0]   alu_sum;
    logic [4:0]        drivers;
    logic              multi_drive;
    logic              run;
    bus_src_t          bus_src;

    // Program-load mode masks the whole control word.
    assign run = ~prog_mode;

    assign drivers     = {run & eu, run & ea, run & ~n_ce, run & ~n_ei, run & ep};
    assign multi_drive = |(drivers & (drivers - 5'd1));

    // Two's-complement subtract: A + ~B + 1, carry=1 means no borrow.
    assign b_op    = su ? ~b : b;
    assign alu_sum = {1'b0, a} + {1'b0, b_op} + (DATA_W + 1)'(su);

    sap1_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (prog_mode & prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (mar),
        .rdata (ram_rdata)
    );

    // Fixed-priority source select: ALU > A > RAM > IR > PC.
    always_comb begin
        bus_src = BUS_NONE;
        if (drivers[4]) begin
            bus_src = BUS_ALU;
        end else if (drivers[3]) begin
            bus_src = BUS_A;
        end else if (drivers[2]) begin
            bus_src = BUS_RAM;
        end else if (drivers[1]) begin
            bus_src = BUS_IR;
        end else if (drivers[0]) begin
            bus_src = BUS_PC;
        end
    end

    always_comb begin
        bus = '0;
        case (bus_src)
            BUS_PC:  bus = {{PAD_W{1'b0}}, pc};
            BUS_IR:  bus = {{PAD_W{1'b0}}, ir[ADDR_W-1:0]};
            BUS_RAM: bus = ram_rdata;
            BUS_A:   bus = a;
            BUS_ALU: bus = alu_sum[DATA_W-1:0];
            default: bus = '0;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pc           <= '0;
            mar          <= '0;
            ir           <= '0;
            a            <= '0;
            b            <= '0;
            out_value    <= '0;
            carry        <= 1'b0;
            zero         <= 1'b0;
            bus_conflict <= 1'b0;
        end else if (run) begin
            if (cp)    pc        <= pc + ADDR_W'(1);
            if (!n_lm) mar       <= bus[ADDR_W-1:0];
            if (!n_li) ir        <= bus;
            if (!n_la) a         <= bus;
            if (!n_lb) b         <= bus;
            if (!n_lo) out_value <= bus;
            // Flags track only ALU results written back into A.
            if (!n_la && eu) begin
                carry <= alu_sum[DATA_W];
                zero  <= (alu_sum[DATA_W-1:0] == '0);
            end
            if (multi_drive) bus_conflict <= 1'b1;
        end
    end

    assign instruction = ir[DATA_W-1:ADDR_W];

endmodule

// File: tb/tb_sap1_datapath.sv
// Directed scoreboard bench for sap1_datapath: expectations queued at stimulus, popped at observation.
module tb_sap1_datapath;
    import sap1_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned OW = DW - AW;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          cp, ep, n_lm, n_ce, n_li, n_ei, n_la, ea, su, eu, n_lb, n_lo;
    logic          prog_mode, prog_we;
    logic [AW-1:0] prog_addr;
    logic [DW-1:0] prog_data;
    logic [OW-1:0] instruction;
    logic [DW-1:0] out_value;
    logic [DW-1:0] bus;
    logic          carry, zero, bus_conflict;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string         tag;
        logic [DW-1:0] exp;
    } exp_t;

    exp_t sb[$];

    sap1_datapath #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .cp           (cp),
        .ep           (ep),
        .n_lm         (n_lm),
        .n_ce         (n_ce),
        .n_li         (n_li),
        .n_ei         (n_ei),
        .n_la         (n_la),
        .ea           (ea),
        .su           (su),
        .eu           (eu),
        .n_lb         (n_lb),
        .n_lo         (n_lo),
        .prog_mode    (prog_mode),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .instruction  (instruction),
        .out_value    (out_value),
        .bus          (bus),
        .carry        (carry),
        .zero         (zero),
        .bus_conflict (bus_conflict)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic want(input string tag, input logic [DW-1:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic got(input logic [DW-1:0] obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %h required queued entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                miscompares++;
                $error("FAIL %s: observed %h required %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic idle();
        cp = 1'b0; ep = 1'b0; n_lm = 1'b1; n_ce = 1'b1; n_li = 1'b1; n_ei = 1'b1;
        n_la = 1'b1; ea = 1'b0; su = 1'b0; eu = 1'b0; n_lb = 1'b1; n_lo = 1'b1;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic prog_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        prog_mode = 1'b1;
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        tick();
        prog_we   = 1'b0;
    endtask

    // MAR sits at 5 whenever this is used; RAM[5] is the staging word for A/B.
    task automatic ram_to(input logic [DW-1:0] data, input logic to_b);
        prog_write(4'h5, data);
        prog_mode = 1'b0;
        idle();
        n_ce = 1'b0;
        if (to_b) n_lb = 1'b0;
        else      n_la = 1'b0;
        tick();
        idle();
    endtask

    task automatic fetch();
        idle(); ep = 1'b1; n_lm = 1'b0; tick();
        idle(); cp = 1'b1; tick();
        idle(); n_ce = 1'b0; n_li = 1'b0; tick();
        idle();
    endtask

    initial begin
        n_rst     = 1'b0;
        prog_mode = 1'b0;
        idle();
        tick();
        tick();
        n_rst = 1'b1;
        settle();

        want("rst_bus", 8'h00);          got(bus);
        want("rst_out", 8'h00);          got(out_value);
        want("rst_instr", 8'h00);        got(DW'(instruction));
        want("rst_conflict", 8'h00);     got(DW'(bus_conflict));
        want("rst_carry_zero", 8'h00);   got({6'b0, carry, zero});

        // Program load while control lines try to disturb the datapath.
        prog_write(4'h0, 8'h1E);
        prog_write(4'hE, 8'h05);
        prog_write(4'h5, 8'hA5);
        ep = 1'b1; ea = 1'b1; n_la = 1'b0; n_lm = 1'b0; cp = 1'b1;
        settle();
        want("prog_bus_masked", 8'h00);  got(bus);
        tick();
        want("prog_no_conflict", 8'h00); got(DW'(bus_conflict));
        idle();
        prog_mode = 1'b0;

        ep = 1'b1; n_lm = 1'b0; settle();
        want("fetch_pc0", 8'h00);        got(bus);
        tick(); idle();
        n_ce = 1'b0; n_li = 1'b0; settle();
        want("fetch_ram0", 8'h1E);       got(bus);
        tick(); idle();
        want("ir_opcode", DW'(OP_LDA));  got(DW'(instruction));
        n_ei = 1'b0; n_lm = 1'b0; settle();
        want("ir_addr", 8'h0E);          got(bus);
        tick(); idle();
        n_ce = 1'b0; n_la = 1'b0; settle();
        want("ram14", 8'h05);            got(bus);
        tick(); idle();
        ea = 1'b1; settle();
        want("a_loaded", 8'h05);         got(bus);
        idle();
        n_ce = 1'b0; n_lm = 1'b0; settle();
        want("lm_ce_old_mar", 8'h05);    got(bus);
        tick(); idle();
        n_ce = 1'b0; settle();
        want("mar_now5", 8'hA5);         got(bus);
        idle();

        for (int i = 0; i < 16; i++) begin
            ep = 1'b1; cp = 1'b1; settle();
            want($sformatf("pc_ep_cp_%0d", i), DW'(i)); got(bus);
            tick(); idle();
        end
        ep = 1'b1; settle();
        want("pc_wrapped", 8'h00);       got(bus);
        idle();

        ram_to(8'hF0, 1'b0);
        ram_to(8'h20, 1'b1);
        eu = 1'b1; n_la = 1'b0; settle();
        want("add_bus", 8'h10);          got(bus);
        tick(); idle();
        ea = 1'b1; settle();
        want("add_a", 8'h10);            got(bus);
        want("add_flags", 8'h02);        got({6'b0, carry, zero});
        idle();

        ram_to(8'h05, 1'b0);
        ram_to(8'h05, 1'b1);
        su = 1'b1; eu = 1'b1; n_la = 1'b0; settle();
        want("sub_bus", 8'h00);          got(bus);
        tick(); idle();
        want("sub_flags", 8'h03);        got({6'b0, carry, zero});
        eu = 1'b1; settle();
        want("add_no_load", 8'h05);      got(bus);
        tick(); idle();
        want("flags_hold", 8'h03);       got({6'b0, carry, zero});

        ram_to(8'h33, 1'b0);
        want("no_conflict_yet", 8'h00);  got(DW'(bus_conflict));
        ea = 1'b1; ep = 1'b1; settle();
        want("conflict_a_wins", 8'h33);  got(bus);
        tick(); idle();
        want("conflict_set", 8'h01);     got(DW'(bus_conflict));
        tick(); tick();
        want("conflict_sticky", 8'h01);  got(DW'(bus_conflict));
        eu = 1'b1; ea = 1'b1; settle();
        want("alu_over_a", 8'h38);       got(bus);
        idle();

        // Mid-run reset: registers clear without waiting for an edge.
        want("pre_rst_instr", 8'h01);    got(DW'(instruction));
        ea = 1'b1;
        n_rst = 1'b0; settle();
        want("mid_rst_a", 8'h00);        got(bus);
        want("mid_rst_instr", 8'h00);    got(DW'(instruction));
        want("mid_rst_conflict", 8'h00); got(DW'(bus_conflict));
        want("mid_rst_flags", 8'h00);    got({6'b0, carry, zero});
        idle();
        tick();
        n_rst = 1'b1;

        prog_write(4'h1, {OP_ADD, 4'hF});
        prog_write(4'h2, {OP_OUT, 4'h0});
        prog_write(4'h3, {OP_HLT, 4'h0});
        prog_write(4'hE, 8'h07);
        prog_write(4'hF, 8'h09);
        prog_mode = 1'b0;
        idle();

        fetch();
        want("run_lda", DW'(OP_LDA));    got(DW'(instruction));
        n_ei = 1'b0; n_lm = 1'b0; tick(); idle();
        n_ce = 1'b0; n_la = 1'b0; tick(); idle();

        fetch();
        want("run_add", DW'(OP_ADD));    got(DW'(instruction));
        n_ei = 1'b0; n_lm = 1'b0; tick(); idle();
        n_ce = 1'b0; n_lb = 1'b0; tick(); idle();
        eu = 1'b1; n_la = 1'b0; settle();
        want("run_alu", 8'h10);          got(bus);
        tick(); idle();

        fetch();
        want("run_out", DW'(OP_OUT));    got(DW'(instruction));
        ea = 1'b1; n_lo = 1'b0; tick(); idle();

        fetch();
        want("run_hlt", DW'(OP_HLT));    got(DW'(instruction));
        tick(); tick();
        want("run_out_value", 8'h10);    got(out_value);
        want("run_flags", 8'h00);        got({6'b0, carry, zero});
        want("run_no_conflict", 8'h00);  got(DW'(bus_conflict));

        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
